// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: ID/EX control fields in, pipeline hold/flush and debug counters out.
// Latency: none (wires only). Backpressure: n/a, the stall outputs are the pipeline's backpressure.
// Master is the pipeline/bench side, slave is hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  i_id_rs1_addr;
    logic [4:0]  i_id_rs2_addr;
    logic        i_id_is_rs1;
    logic        i_id_is_rs2;
    logic [4:0]  i_ex_rd_addr;
    logic        i_ex_rd_wren;
    logic        i_ex_mem_rden;
    logic        i_ex_redirect;
    logic        i_cnt_clr;
    logic        o_pc_stall;
    logic        o_if_id_stall;
    logic        o_if_id_flush;
    logic        o_id_ex_flush;
    logic [31:0] o_stall_cycles;
    logic [31:0] o_flush_events;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_is_rs1, i_id_is_rs2,
        output i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden, i_ex_redirect, i_cnt_clr,
        input  o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
        input  o_stall_cycles, o_flush_events
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_is_rs1, i_id_is_rs2,
        input  i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden, i_ex_redirect, i_cnt_clr,
        output o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush,
        output o_stall_cycles, o_flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / redirect flush controller with saturating stall and flush debug counters.
// Latency: 0 cycles, controls are combinational from state and inputs. Backpressure: none accepted;
// it generates the pipeline's stall/bubble signals itself.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        IDLE,
        LD_STALL
    } state_t;

    localparam logic [2:0]  REM_INIT = 3'(LOAD_STALL - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [2:0]  rem_q, rem_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic rs1_hit, rs2_hit, lu;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush;

    assign rs1_hit = hz.i_id_is_rs1 && (hz.i_id_rs1_addr == hz.i_ex_rd_addr);
    assign rs2_hit = hz.i_id_is_rs2 && (hz.i_id_rs2_addr == hz.i_ex_rd_addr);
    assign lu      = hz.i_ex_mem_rden && hz.i_ex_rd_wren && (hz.i_ex_rd_addr != 5'd0)
                     && (rs1_hit || rs2_hit);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        // A redirect kills the wrong-path work in IF/ID and EX, so it wins over any stall.
        if (hz.i_ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = IDLE;
            rem_d       = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lu) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = LD_STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                LD_STALL: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    rem_d       = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.i_cnt_clr) begin
            stall_cnt_d = 32'd0;
            flush_cnt_d = 32'd0;
        end else begin
            if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (hz.i_ex_redirect && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rem_q       <= 3'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are masked during reset so no bubble leaks out before the state register settles.
    assign hz.o_pc_stall     = pc_stall    && i_rst_n;
    assign hz.o_if_id_stall  = if_id_stall && i_rst_n;
    assign hz.o_if_id_flush  = if_id_flush && i_rst_n;
    assign hz.o_id_ex_flush  = id_ex_flush && i_rst_n;
    assign hz.o_stall_cycles = stall_cnt_q;
    assign hz.o_flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL 1, 3, 4) share stimulus and are checked
// against a bubbles-owed reference model, plus vector tables and directed corner sequences.
module tb_hazard_ctrl;

    localparam int LS_A = 1;
    localparam int LS_B = 3;
    localparam int LS_C = 4;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, rd;
    logic       is1, is2, wren, rden, redir, clr;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();
    hazard_ctrl_if if_c ();

    hazard_ctrl #(.LOAD_STALL(LS_A)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .hz(if_a.slave));
    hazard_ctrl #(.LOAD_STALL(LS_B)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .hz(if_b.slave));
    hazard_ctrl #(.LOAD_STALL(LS_C)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .hz(if_c.slave));

    assign {if_a.i_id_rs1_addr, if_b.i_id_rs1_addr, if_c.i_id_rs1_addr} = {3{rs1}};
    assign {if_a.i_id_rs2_addr, if_b.i_id_rs2_addr, if_c.i_id_rs2_addr} = {3{rs2}};
    assign {if_a.i_id_is_rs1, if_b.i_id_is_rs1, if_c.i_id_is_rs1}       = {3{is1}};
    assign {if_a.i_id_is_rs2, if_b.i_id_is_rs2, if_c.i_id_is_rs2}       = {3{is2}};
    assign {if_a.i_ex_rd_addr, if_b.i_ex_rd_addr, if_c.i_ex_rd_addr}    = {3{rd}};
    assign {if_a.i_ex_rd_wren, if_b.i_ex_rd_wren, if_c.i_ex_rd_wren}    = {3{wren}};
    assign {if_a.i_ex_mem_rden, if_b.i_ex_mem_rden, if_c.i_ex_mem_rden} = {3{rden}};
    assign {if_a.i_ex_redirect, if_b.i_ex_redirect, if_c.i_ex_redirect} = {3{redir}};
    assign {if_a.i_cnt_clr, if_b.i_cnt_clr, if_c.i_cnt_clr}             = {3{clr}};

    // ctl bits: {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
    logic [3:0]  ctl [3];
    logic [31:0] sc  [3];
    logic [31:0] fe  [3];
    assign ctl[0] = {if_a.o_pc_stall, if_a.o_if_id_stall, if_a.o_if_id_flush, if_a.o_id_ex_flush};
    assign ctl[1] = {if_b.o_pc_stall, if_b.o_if_id_stall, if_b.o_if_id_flush, if_b.o_id_ex_flush};
    assign ctl[2] = {if_c.o_pc_stall, if_c.o_if_id_stall, if_c.o_if_id_flush, if_c.o_id_ex_flush};
    assign sc[0] = if_a.o_stall_cycles;
    assign sc[1] = if_b.o_stall_cycles;
    assign sc[2] = if_c.o_stall_cycles;
    assign fe[0] = if_a.o_flush_events;
    assign fe[1] = if_b.o_flush_events;
    assign fe[2] = if_c.o_flush_events;

    int checks = 0;
    int errors = 0;

    // Reference model: bubbles still owed after this cycle, and event counts.
    int     owed [3];
    longint esc  [3];
    longint efe  [3];

    function automatic int ls_of(input int k);
        return (k == 0) ? LS_A : (k == 1) ? LS_B : LS_C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                          input logic s1, input logic s2, input logic w, input logic r,
                          input logic rdr);
        rs1 = a1; rs2 = a2; rd = d; is1 = s1; is2 = s2; wren = w; rden = r; redir = rdr;
    endtask

    task automatic clear_in();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
    endtask

    // Called at a negedge with inputs settled; checks all instances, advances the model one cycle.
    task automatic step();
        logic [3:0] e;
        logic       hit;
        #1;
        hit = rden && wren && (rd != 5'd0) && ((is1 && rs1 == rd) || (is2 && rs2 == rd));
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                owed[k] = 0; esc[k] = 0; efe[k] = 0;
                e = 4'b0000;
            end else if (redir) begin
                e = 4'b0011;
                owed[k] = 0;
            end else if (owed[k] > 0) begin
                e = 4'b1101;
                owed[k] = owed[k] - 1;
            end else if (hit) begin
                e = 4'b1101;
                owed[k] = ls_of(k) - 1;
            end else begin
                e = 4'b0000;
            end
            chk($sformatf("ctl[%0d]", k), {28'd0, ctl[k]}, {28'd0, e});
            chk($sformatf("stall_cycles[%0d]", k), sc[k], esc[k][31:0]);
            chk($sformatf("flush_events[%0d]", k), fe[k], efe[k][31:0]);
            if (rst_n) begin
                if (clr) begin
                    esc[k] = 0; efe[k] = 0;
                end else begin
                    if (e[3]) esc[k] = (esc[k] + 1 > CMAX) ? CMAX : esc[k] + 1;
                    if (redir) efe[k] = (efe[k] + 1 > CMAX) ? CMAX : efe[k] + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       is1, is2, wren, rden, redir;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] sc_pre, fe_pre;

    initial begin
        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1101};
        vecs[1] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[2] = '{5'd5,  5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[3] = '{5'd3,  5'd7,  5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101};
        vecs[4] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[6] = '{5'd9,  5'd2,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011};
        vecs[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[8] = '{5'd4,  5'd6,  5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[9] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101};

        clear_in();
        for (int k = 0; k < 3; k++) begin
            owed[k] = 0; esc[k] = 0; efe[k] = 0;
        end
        @(negedge clk);

        // Reset state
        rst_n = 1'b0;
        step();
        chk("reset_ctl_b", {28'd0, ctl[1]}, 32'd0);
        chk("reset_sc_b", sc[1], 32'd0);
        rst_n = 1'b1;
        step();

        // lw x5 then dependent use, single bubble
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("ls1_stall", {28'd0, ctl[0]}, 32'hD);
        step();
        clear_in();
        #1 chk("ls1_after", {28'd0, ctl[0]}, 32'd0);
        step();
        chk("ls1_count", sc[0], 32'd1);

        // Three bubbles with EX fields held
        do_reset();
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("ls3_stall%0d", i), {28'd0, ctl[1]}, 32'hD);
            step();
        end
        clear_in();
        #1 chk("ls3_after", {28'd0, ctl[1]}, 32'd0);
        step();
        chk("ls3_count", sc[1], 32'd3);

        // Single-cycle decode table on the LOAD_STALL=1 instance
        for (int v = 0; v < 10; v++) begin
            set_in(vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].is1, vecs[v].is2,
                   vecs[v].wren, vecs[v].rden, vecs[v].redir);
            #1 chk($sformatf("vec%0d", v), {28'd0, ctl[0]}, {28'd0, vecs[v].exp});
            step();
        end
        clear_in();
        for (int i = 0; i < 5; i++) step();

        // Redirect with a simultaneous load-use hit
        sc_pre = sc[0];
        fe_pre = fe[0];
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk("redir_ctl", {28'd0, ctl[0]}, 32'h3);
        step();
        clear_in();
        chk("redir_fe", fe[0], fe_pre + 32'd1);
        chk("redir_sc", sc[0], sc_pre);
        step();

        // Reset asserted on the second stall cycle of a 4-bubble stall
        set_in(5'd6, 5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        clear_in();
        rst_n = 1'b0;
        #1 chk("rstmid_ctl", {28'd0, ctl[2]}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rstmid_idle%0d", i), {28'd0, ctl[2]}, 32'd0);
            step();
        end
        chk("rstmid_sc", sc[2], 32'd0);
        chk("rstmid_fe", fe[2], 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            is1   = 1'($urandom_range(0, 1));
            is2   = 1'($urandom_range(0, 1));
            wren  = ($urandom_range(0, 3) != 0);
            rden  = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            clr   = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        clear_in();
        for (int i = 0; i < 6; i++) step();

        // Saturation of the stall counter, then clear during a stall
        @(posedge clk);
        force dut_b.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut_b.stall_cnt_q;
        @(negedge clk);
        esc[1] = 64'h0000_0000_FFFF_FFFE;
        set_in(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        clear_in();
        step();
        step();
        chk("sat_sc", sc[1], 32'hFFFF_FFFF);
        set_in(5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        clr = 1'b1;
        #1 chk("clr_stalling", {28'd0, ctl[1]}, 32'hD);
        step();
        chk("clr_sc", sc[1], 32'd0);
        chk("clr_fe", fe[1], 32'd0);
        clear_in();
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
